muldiv_seq: RTL and testbench

//  Multi-cycle 8-bit unsigned multiply/divide sequencer. Reuses one ripple adder (add) and
//  one subtractor (subtract) per iteration: shift-add for MUL, restoring shift-subtract for DIV.

---
 rtl/muldiv_seq_pkg.sv | 22 ++
 rtl/muldiv_seq_arith.sv | 31 +++
 rtl/muldiv_seq.sv | 144 ++++++++++++++
 tb/tb_muldiv_seq.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_seq_pkg.sv
// Shared definitions for the multiply/divide sequencer: opcode values,
// FSM state encoding and iteration bounds.
package muldiv_seq_pkg;

  // Datapath width of the shared add/subtract units.
  localparam int DATA_W = 8;

  // Opcode on the op input.
  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  // Index of the last of the eight shift iterations.
  localparam logic [2:0] ITER_LAST = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

endpackage : muldiv_seq_pkg

// File: rtl/muldiv_seq_arith.sv
// Fixed 8-bit ripple adder and subtractor used by the sequencer, one
// evaluation per iteration.

// 8-bit adder with carry-out.
module add
  import muldiv_seq_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] sum,
  output logic              carry
);

  assign {carry, sum} = {1'b0, a} + {1'b0, b};

endmodule : add

// 8-bit subtractor a - b; carry is the no-borrow flag (1 when a >= b).
module subtract
  import muldiv_seq_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] diff,
  output logic              carry
);

  // Two's-complement subtraction: a + ~b + 1, carry-out means no borrow.
  assign {carry, diff} = {1'b0, a} + {1'b0, ~b} + {{DATA_W{1'b0}}, 1'b1};

endmodule : subtract

// File: rtl/muldiv_seq.sv
// Multi-cycle 8-bit unsigned multiply/divide sequencer. Shift-add multiply and
// restoring shift-subtract divide, eight iterations each, sharing one adder and
// one subtractor. start/busy/done handshake; results held until next accept.
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int               WIDTH  = 8,
  parameter logic [WIDTH-1:0] DIV0_Q = 8'hFF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             div_by_zero
);

  state_t           state;
  logic [2:0]       iter;
  logic [WIDTH-1:0] hi;    // MUL: accumulator;          DIV: partial remainder
  logic [WIDTH-1:0] lo;    // MUL: multiplier shift reg; DIV: dividend/quotient shift reg
  logic [WIDTH-1:0] opnd;  // MUL: multiplicand;         DIV: divisor

  // Multiply step: add the multiplicand when the current multiplier bit is set,
  // then shift {carry, sum, lo} right by one.
  logic [WIDTH-1:0] mul_addend;
  logic [WIDTH-1:0] mul_sum;
  logic             mul_carry;
  logic [WIDTH-1:0] mul_hi_next;
  logic [WIDTH-1:0] mul_lo_next;

  assign mul_addend = lo[0] ? opnd : '0;

  add u_add (
    .a     (hi),
    .b     (mul_addend),
    .sum   (mul_sum),
    .carry (mul_carry)
  );

  assign mul_hi_next = {mul_carry, mul_sum[WIDTH-1:1]};
  assign mul_lo_next = {mul_sum[0], lo[WIDTH-1:1]};

  // Divide step: shift the next dividend bit into the remainder. The bit that
  // falls out of the remainder (div_msb) makes the 9-bit value exceed any
  // divisor, in which case the 8-bit difference is already the right residue.
  logic             div_msb;
  logic [WIDTH-1:0] div_t;
  logic [WIDTH-1:0] div_diff;
  logic             div_no_borrow;
  logic             div_qbit;
  logic [WIDTH-1:0] div_r_next;
  logic [WIDTH-1:0] div_q_next;

  assign div_msb = hi[WIDTH-1];
  assign div_t   = {hi[WIDTH-2:0], lo[WIDTH-1]};

  subtract u_sub (
    .a     (div_t),
    .b     (opnd),
    .diff  (div_diff),
    .carry (div_no_borrow)
  );

  assign div_qbit   = div_msb | div_no_borrow;
  assign div_r_next = div_qbit ? div_diff : div_t;
  assign div_q_next = {lo[WIDTH-2:0], div_qbit};

  // Handshake flags decode directly from the state register.
  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  // Sequencer FSM, iteration counter, working registers and held results.
  // NOTE: every register here uses non-blocking assignment so all next-state
  // values are computed from the same pre-edge snapshot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      iter        <= '0;
      hi          <= '0;
      lo          <= '0;
      opnd        <= '0;
      result_lo   <= '0;
      result_hi   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            iter        <= '0;
            hi          <= '0;
            div_by_zero <= 1'b0;
            if (op == OP_MUL) begin
              opnd  <= a;
              lo    <= b;
              state <= S_MUL;
            end else if (b == '0) begin
              result_lo   <= DIV0_Q;
              result_hi   <= a;
              div_by_zero <= 1'b1;
              state       <= S_DONE;
            end else begin
              opnd  <= b;
              lo    <= a;
              state <= S_DIV;
            end
          end
        end

        S_MUL: begin
          hi   <= mul_hi_next;
          lo   <= mul_lo_next;
          iter <= iter + 3'd1;
          if (iter == ITER_LAST) begin
            result_hi <= mul_hi_next;
            result_lo <= mul_lo_next;
            state     <= S_DONE;
          end
        end

        S_DIV: begin
          hi   <= div_r_next;
          lo   <= div_q_next;
          iter <= iter + 3'd1;
          if (iter == ITER_LAST) begin
            result_hi <= div_r_next;
            result_lo <= div_q_next;
            state     <= S_DONE;
          end
        end

        S_DONE: state <= S_IDLE;

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule : muldiv_seq

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: vector table plus hand-written
// sequences for ignored starts and mid-operation reset. Expected results go
// into a scoreboard queue at issue and are compared when done pulses.
module tb_muldiv_seq;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       op;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [7:0] result_lo;
  logic [7:0] result_hi;
  logic       div_by_zero;

  muldiv_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .result_lo   (result_lo),
    .result_hi   (result_hi),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] lo;
    logic [7:0] hi;
    logic       dbz;
    int         lat;
  } vec_t;

  typedef struct packed {
    logic [7:0] lo;
    logic [7:0] hi;
    logic       dbz;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every done pulse must match the oldest pending result.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 16'd1, 16'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result_lo", {8'h00, result_lo}, {8'h00, e.lo});
        check("result_hi", {8'h00, result_hi}, {8'h00, e.hi});
        check("div_by_zero", {15'd0, div_by_zero}, {15'd0, e.dbz});
      end
    end
  end

  // Wait for done, counting negedges since the last accept and busy cycles.
  task automatic wait_done(output int cyc, output int bcnt);
    bit ok;
    cyc  = 0;
    bcnt = 0;
    ok   = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      cyc++;
      if (busy) bcnt++;
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("done_timeout", 16'd0, 16'd1);
  endtask

  // Issue one operation, scramble inputs after accept, check timing and hold.
  task automatic do_op(input vec_t v);
    int cyc;
    int bcnt;
    @(negedge clk);
    op    = v.op;
    a     = v.a;
    b     = v.b;
    start = 1'b1;
    sb.push_back('{lo: v.lo, hi: v.hi, dbz: v.dbz});
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = 8'($urandom);
    b     = 8'($urandom);
    op    = 1'($urandom);
    check("busy_after_accept", {15'd0, busy}, 16'd1);
    wait_done(cyc, bcnt);
    check("latency", 16'(cyc), 16'(v.lat));
    check("busy_cycles", 16'(bcnt), 16'(v.lat));
    @(negedge clk);
    check("idle_after_done", {14'd0, busy, done}, 16'd0);
    check("held_result", {result_hi, result_lo}, {v.hi, v.lo});
  endtask

  vec_t vecs[$];

  initial begin
    int cyc;
    int bcnt;
    int done_cnt;

    rst_n = 1'b0;
    start = 1'b0;
    op    = 1'b0;
    a     = '0;
    b     = '0;

    // Reset state.
    #1;
    check("reset_outputs", {result_hi, result_lo}, 16'h0000);
    check("reset_flags", {13'd0, busy, done, div_by_zero}, 16'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    //                 op  a       b       lo      hi      dbz  lat
    vecs.push_back('{1'b0, 8'd13,  8'd11,  8'h8F,  8'h00,  1'b0, 9});
    vecs.push_back('{1'b0, 8'd255, 8'd255, 8'h01,  8'hFE,  1'b0, 9});
    vecs.push_back('{1'b0, 8'd0,   8'd200, 8'h00,  8'h00,  1'b0, 9});
    vecs.push_back('{1'b0, 8'd128, 8'd2,   8'h00,  8'h01,  1'b0, 9});
    vecs.push_back('{1'b1, 8'd200, 8'd7,   8'h1C,  8'h04,  1'b0, 9});
    vecs.push_back('{1'b1, 8'd5,   8'd9,   8'h00,  8'h05,  1'b0, 9});
    vecs.push_back('{1'b1, 8'd200, 8'd129, 8'h01,  8'd71,  1'b0, 9});
    vecs.push_back('{1'b1, 8'd255, 8'd1,   8'hFF,  8'h00,  1'b0, 9});
    vecs.push_back('{1'b1, 8'd255, 8'd16,  8'h0F,  8'h0F,  1'b0, 9});
    vecs.push_back('{1'b1, 8'd42,  8'd0,   8'hFF,  8'h2A,  1'b1, 1});
    vecs.push_back('{1'b0, 8'd3,   8'd5,   8'h0F,  8'h00,  1'b0, 9});

    foreach (vecs[i]) do_op(vecs[i]);

    // Starts at accept+3 and in the done cycle are ignored; a start held into
    // the first IDLE cycle after done is accepted.
    @(negedge clk);
    op    = 1'b0;
    a     = 8'd13;
    b     = 8'd11;
    start = 1'b1;
    sb.push_back('{lo: 8'h8F, hi: 8'h00, dbz: 1'b0});
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    op    = 1'b1;
    a     = 8'd9;
    b     = 8'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(cyc, bcnt);
    check("ignore_latency", 16'(cyc + 4), 16'd9);
    op    = 1'b0;
    a     = 8'd2;
    b     = 8'd3;
    start = 1'b1;
    @(negedge clk);
    check("idle_after_ignored_start", {15'd0, busy}, 16'd0);
    check("first_op_held", {result_hi, result_lo}, 16'h008F);
    sb.push_back('{lo: 8'h06, hi: 8'h00, dbz: 1'b0});
    @(posedge clk);
    #1;
    start = 1'b0;
    check("accept_in_idle", {15'd0, busy}, 16'd1);
    wait_done(cyc, bcnt);
    check("second_op_latency", 16'(cyc), 16'd9);

    // Reset at accept+4 of a MUL aborts it: outputs clear, no done follows.
    @(negedge clk);
    op    = 1'b0;
    a     = 8'd50;
    b     = 8'd60;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_results", {result_hi, result_lo}, 16'h0000);
    check("abort_flags", {13'd0, busy, done, div_by_zero}, 16'd0);
    done_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 1) rst_n = 1'b1;
      if (done) done_cnt++;
    end
    check("no_done_after_abort", 16'(done_cnt), 16'd0);

    do_op('{1'b1, 8'd100, 8'd10, 8'd10, 8'd0, 1'b0, 9});

    check("scoreboard_empty", 16'(sb.size()), 16'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_muldiv_seq
